// File: rtl/facto_ctrl.sv
// Sequencing controller for the factorial peripheral: computes N! by iterating an external W x W -> 2W multiplier.
// Optional overflow detection is enabled by defining FACTO_OVF_CHECK_EN.
module facto_ctrl #(
  parameter int unsigned W = 64
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           clear,
  input  logic           intr_en,
  input  logic [W-1:0]   operand,
  input  logic           mul_done,
  input  logic [2*W-1:0] mul_result,
  output logic           mul_start,
  output logic           mul_clear,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  output logic           busy,
  output logic           done,
  output logic           intr,
  output logic           ovf,
  output logic [W-1:0]   result_h,
  output logic [W-1:0]   result_l
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MUL_REQ,
    MUL_WAIT,
    FIN
  } state_t;

  state_t         state;
  logic [W-1:0]   cnt;
  logic [2*W-1:0] product;
  logic           ovf_hit;

`ifdef FACTO_OVF_CHECK_EN
  // Any bit above W means the next multiply would feed a truncated multiplicand.
  assign ovf_hit = |product[2*W-1:W];
`else
  assign ovf_hit = 1'b0;
`endif

  assign result_h = product[2*W-1:W];
  assign result_l = product[W-1:0];
  assign intr     = done & intr_en;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      product   <= '0;
      mul_start <= 1'b0;
      mul_clear <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      mul_clear <= 1'b0;
      if (clear) begin
        // Clear outranks start and any mul_done landing in the same cycle.
        mul_clear <= (state == MUL_WAIT);
        state     <= IDLE;
        cnt       <= '0;
        product   <= '0;
        busy      <= 1'b0;
        done      <= 1'b0;
        ovf       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !done) begin
              cnt     <= operand;
              product <= {{(2*W-1){1'b0}}, 1'b1};
              ovf     <= 1'b0;
              busy    <= 1'b1;
              state   <= CHECK;
            end
          end
          CHECK: begin
            if (cnt <= W'(1)) begin
              busy  <= 1'b0;
              state <= FIN;
            end else if (ovf_hit) begin
              ovf   <= 1'b1;
              busy  <= 1'b0;
              state <= FIN;
            end else begin
              mul_start <= 1'b1;
              mul_a     <= product[W-1:0];
              mul_b     <= cnt;
              state     <= MUL_REQ;
            end
          end
          MUL_REQ: begin
            state <= MUL_WAIT;
          end
          MUL_WAIT: begin
            if (mul_done) begin
              product <= mul_result;
              cnt     <= cnt - W'(1);
              state   <= CHECK;
            end
          end
          FIN: begin
            done  <= 1'b1;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_facto_ctrl.sv
// Self-checking bench for facto_ctrl: arithmetic factorial model, scoreboard of multiplier requests, directed vectors.
module tb_facto_ctrl;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic         clear;
  logic         intr_en;
  logic [63:0]  operand;
  logic         mul_done;
  logic [127:0] mul_result;
  logic         mul_start;
  logic         mul_clear;
  logic [63:0]  mul_a;
  logic [63:0]  mul_b;
  logic         busy;
  logic         done;
  logic         intr;
  logic         ovf;
  logic [63:0]  result_h;
  logic [63:0]  result_l;

  int checks = 0;
  int errors = 0;
  int nstart = 0;
  int nclr   = 0;
  logic cmp_on = 1'b0;
  logic [127:0] exp_ops[$];

  facto_ctrl #(.W(64)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .clear(clear),
    .intr_en(intr_en), .operand(operand), .mul_done(mul_done),
    .mul_result(mul_result), .mul_start(mul_start), .mul_clear(mul_clear),
    .mul_a(mul_a), .mul_b(mul_b), .busy(busy), .done(done), .intr(intr),
    .ovf(ovf), .result_h(result_h), .result_l(result_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // N! by repeated multiplication, largest factor first, one request per factor >= 2.
  function automatic void model(input logic [63:0] n, output logic [127:0] res,
                                output logic ov, output int nm);
    logic [127:0] p;
    logic [63:0]  k;
    p = 128'd1; k = n; ov = 1'b0; nm = 0;
    while (k > 64'd1) begin
`ifdef FACTO_OVF_CHECK_EN
      if (p[127:64] != 64'd0) begin
        ov = 1'b1;
        break;
      end
`endif
      exp_ops.push_back({p[63:0], k});
      p = {64'd0, p[63:0]} * {64'd0, k};
      k = k - 64'd1;
      nm++;
    end
    res = p;
  endfunction

  // Per-cycle compare: intr relation and every multiplier request against the model's queue.
  initial begin
    logic [127:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (cmp_on) begin
        chk("intr_eq_done_and_en", intr, done & intr_en);
        if (mul_start) begin
          nstart++;
          if (exp_ops.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mul_start_unexpected actual=1 expected=0 b=%0d", mul_b);
          end else begin
            e = exp_ops.pop_front();
            chk("mul_a", mul_a, e[127:64]);
            chk("mul_b", mul_b, e[63:0]);
          end
        end
        if (mul_clear) nclr++;
      end
    end
  end

  // Issues start at the current negedge and plays a fixed-latency multiplier until done.
  task automatic run_fact(input logic [63:0] n, input int lat, input int poke_k, output int cyc);
    logic [127:0] res;
    logic         ov;
    int           nm, ms0, k, cd;
    logic         pend, got;
    logic [63:0]  pa, pb;
    model(n, res, ov, nm);
    ms0 = nstart; k = 0; cd = 0; pend = 0; got = 0; pa = '0; pb = '0;
    operand = n;
    start = 1'b1;
    while (k < 2000) begin
      @(negedge clk);
      k++;
      mul_done = 1'b0;
      if (k == 1) begin
        start = 1'b0;
        chk("busy_after_start", busy, 1);
      end
      if (poke_k != 0 && k == poke_k) begin
        operand = 64'd9;
        start = 1'b1;
      end
      if (poke_k != 0 && k == poke_k + 1) start = 1'b0;
      if (pend) begin
        cd--;
        if (cd == 0) begin
          mul_done = 1'b1;
          mul_result = {64'd0, pa} * {64'd0, pb};
          pend = 1'b0;
        end
      end
      if (mul_start) begin
        pend = 1'b1; cd = lat; pa = mul_a; pb = mul_b;
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    cyc = k;
    chk("done_within_budget", got, 1);
    chk("done_latency", k, 3 + nm * (2 + lat));
    chk("result", {result_h, result_l}, res);
    chk("ovf", ovf, ov);
    chk("busy_at_done", busy, 0);
    chk("mul_start_count", nstart - ms0, nm);
    chk("requests_outstanding", exp_ops.size(), 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_done", done, 0);
    chk("clear_ovf", ovf, 0);
    chk("clear_result", {result_h, result_l}, 128'd0);
  endtask

  initial begin
    int cyc, n0, k;
    logic seen;
    reset_n = 1'b0; start = 1'b1; clear = 1'b0; intr_en = 1'b1;
    operand = 64'd5; mul_done = 1'b0; mul_result = '0;

    // Reset dominates a simultaneous start
    repeat (3) @(negedge clk);
    cmp_on = 1'b1;
    chk("rst_result_h", result_h, 0);
    chk("rst_result_l", result_l, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_intr", intr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_mul_clear", mul_clear, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    reset_n = 1'b1; start = 1'b0; intr_en = 1'b0;
    @(negedge clk);
    chk("idle_after_reset_busy", busy, 0);

    // 5! with L=3
    run_fact(64'd5, 3, 0, cyc);
    chk("fact5_cycles", cyc, 23);
    chk("fact5_value", result_l, 64'd120);
    chk("fact5_high", result_h, 0);
    chk("fact5_done", done, 1);

    // start while done=1 and a stray mul_done are both ignored
    operand = 64'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("start_while_done_result", result_l, 64'd120);
    chk("start_while_done_busy", busy, 0);
    mul_result = 128'hDEAD_BEEF; mul_done = 1'b1;
    @(negedge clk);
    mul_done = 1'b0;
    @(negedge clk);
    chk("stray_mul_done_result", result_l, 64'd120);
    chk("stray_mul_done_done", done, 1);
    n0 = nclr;
    do_clear();
    @(negedge clk);
    chk("no_mul_clear_from_idle", nclr - n0, 0);

    // N = 0 and N = 1
    run_fact(64'd0, 3, 0, cyc);
    chk("fact0_cycles", cyc, 3);
    chk("fact0_value", result_l, 64'd1);
    do_clear();
    run_fact(64'd1, 3, 0, cyc);
    chk("fact1_cycles", cyc, 3);
    chk("fact1_value", result_l, 64'd1);
    do_clear();

    // 20! with interrupt, then intr_en dropped while done stays
    intr_en = 1'b1;
    run_fact(64'd20, 2, 0, cyc);
    chk("fact20_value", result_l, 64'h21C3677C82B40000);
    chk("fact20_high", result_h, 0);
    chk("fact20_intr", intr, 1);
    intr_en = 1'b0;
    #1;
    chk("intr_after_en_drop", intr, 0);
    chk("done_after_en_drop", done, 1);
    @(negedge clk);
    do_clear();

    // 25!: truncation or overflow stop depending on build
    run_fact(64'd25, 1, 0, cyc);
`ifdef FACTO_OVF_CHECK_EN
    chk("fact25_ovf", ovf, 1);
    chk("fact25_high_nonzero", result_h != 64'd0, 1);
`else
    chk("fact25_ovf", ovf, 0);
    chk("fact25_trunc", result_l, 64'd7034535277573963776);
`endif
    chk("fact25_done", done, 1);
    do_clear();

    // clear during MUL_WAIT with a coincident mul_done
    begin
      logic [127:0] r;
      logic         o;
      int           nm;
      model(64'd6, r, o, nm);
    end
    operand = 64'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (mul_start) seen = 1'b1;
    end
    chk("abort_saw_request", seen, 1);
    @(negedge clk);
    n0 = nclr;
    clear = 1'b1; mul_done = 1'b1; mul_result = 128'h1234_5678;
    @(negedge clk);
    clear = 1'b0; mul_done = 1'b0;
    chk("abort_mul_clear", mul_clear, 1);
    chk("abort_result", {result_h, result_l}, 128'd0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    chk("abort_mul_clear_one_cycle", mul_clear, 0);
    chk("abort_mul_clear_count", nclr - n0, 1);
    exp_ops.delete();
    repeat (4) @(negedge clk);
    chk("abort_result_stays", {result_h, result_l}, 128'd0);

    // start while busy is ignored
    run_fact(64'd5, 2, 3, cyc);
    chk("busy_poke_value", result_l, 64'd120);
    chk("busy_poke_cycles", cyc, 19);
    do_clear();

    // start and clear together in IDLE: clear wins
    operand = 64'd5; start = 1'b1; clear = 1'b1;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_clear_busy", busy, 0);
    chk("start_clear_done", done, 0);
    chk("start_clear_result", {result_h, result_l}, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
